// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset control unit:
// state encoding, opcode/funct values and ULA operation codes.
package mc_pkg;

  // State codes double as the LED debug value, so the encoding is fixed.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ULA operation codes
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

endpackage

// File: rtl/ula_decoder.sv
// Maps an R-type funct field to the ULA operation code.
// Ports:
//   funct    in  6  instr[5:0]
//   ula_ctrl out 3  ULA operation (unknown funct falls back to add)
module ula_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ula_ctrl
);

  // funct -> ULA operation lookup
  always_comb begin
    ula_ctrl = ULA_ADD;
    case (funct)
      FN_ADD:  ula_ctrl = ULA_ADD;
      FN_SUB:  ula_ctrl = ULA_SUB;
      FN_AND:  ula_ctrl = ULA_AND;
      FN_OR:   ula_ctrl = ULA_OR;
      FN_SLT:  ula_ctrl = ULA_SLT;
      default: ula_ctrl = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-FSM sequencer for the 8-bit multicycle MIPS-subset datapath.
// One state advance per clk edge with tick=1.
// Ports:
//   clk, rst (async, active-low), tick (step enable), halt (hold in FETCH)
//   op, funct  instruction fields from the IR; zero  ULA result == 0
//   IorD, ALUSrcA, ALUSrcB, ULAControl, PCSrc, RegDst, MemtoReg  datapath selects
//   IRWrite, MemWrite, RegWrite, PCEn  write strobes (gated by tick and rst)
//   state  current state code; instr_cnt  retired count; illegal  sticky bad-op flag
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             halt,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             IorD,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ULAControl,
  output logic [1:0]       PCSrc,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             PCEn,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] instr_cnt_r;
  logic             illegal_r;
  logic             bad_op_s;
  logic [2:0]       ula_exec_s;
  logic             irwrite_s, memwrite_s, regwrite_s, pcwrite_s, branch_s;
  logic             retire_s;
  logic             step_s;

  ula_decoder u_ula_decoder (
    .funct    (funct),
    .ula_ctrl (ula_exec_s)
  );

  // Strobes must vanish the moment rst drops, so rst gates them combinationally.
  assign step_s   = tick & rst;
  assign retire_s = tick & (state_r != S_FETCH) & (state_next_s == S_FETCH);

  // Next-state selection and illegal-opcode detection
  always_comb begin
    state_next_s = S_FETCH;
    bad_op_s     = 1'b0;
    case (state_r)
      S_FETCH:  state_next_s = halt ? S_FETCH : S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = S_EXEC;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_J:         state_next_s = S_JUMP;
          default: begin
            state_next_s = S_FETCH;
            bad_op_s     = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_next_s = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next_s = S_MEMWB;
      S_EXEC:   state_next_s = S_ALUWB;
      S_ADDIEX: state_next_s = S_ADDIWB;
      default:  state_next_s = S_FETCH;  // write-back/terminal states and unused codes 12-15
    endcase
  end

  // Per-state datapath selects and raw (ungated) strobes
  always_comb begin
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ULAControl = 3'b000;
    PCSrc      = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        ALUSrcB    = 2'b01;
        ULAControl = ULA_ADD;
        irwrite_s  = ~halt;
        pcwrite_s  = ~halt;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ULAControl = ULA_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ULAControl = ULA_ADD;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ULAControl = ula_exec_s;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ULAControl = ULA_SUB;
        PCSrc      = 2'b01;
        branch_s   = 1'b1;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: begin
        IorD = 1'b0;
      end
    endcase
  end

  assign IRWrite   = irwrite_s & step_s;
  assign MemWrite  = memwrite_s & step_s;
  assign RegWrite  = regwrite_s & step_s;
  assign PCEn      = (pcwrite_s | (branch_s & zero)) & step_s;
  assign state     = state_r;
  assign instr_cnt = instr_cnt_r;
  assign illegal   = illegal_r;

  // State register, retired-instruction counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_FETCH;
      instr_cnt_r <= {CNT_W{1'b0}};
      illegal_r   <= 1'b0;
    end else if (tick) begin
      state_r <= state_next_s;
      if (retire_s) begin
        instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bad_op_s && (state_r == S_DECODE)) begin
        illegal_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl. The reference model
// describes each instruction as its list of visited state codes and derives
// expected strobes/selects from which step of that list is active.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst, tick, halt, zero;
  logic [5:0] op, funct;
  logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, PCEn, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ULAControl;
  logic [3:0] state;
  logic [7:0] instr_cnt;

  int   total = 0;
  int   bad   = 0;
  int   m_cnt = 0;
  logic m_illegal = 1'b0;

  multicycle_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .halt(halt), .op(op), .funct(funct), .zero(zero),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ULAControl(ULAControl),
    .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .PCEn(PCEn), .state(state),
    .instr_cnt(instr_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Runs one instruction from FETCH back to FETCH. mode: 0 tick always 1,
  // 1 random tick, 2 repeating tick pattern 1,0,0,1.
  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v,
                           input logic zero_v, input int mode);
    int path[6];
    int len, i, cyc, mw_pulses, s;
    logic t, e_ir, e_mw, e_rw, e_pc;
    path[0] = 0; path[1] = 1;
    case (op_v)
      LW:      begin path[2] = 2; path[3] = 3; path[4] = 4; len = 5; end
      SW:      begin path[2] = 2; path[3] = 5; len = 4; end
      RT:      begin path[2] = 6; path[3] = 7; len = 4; end
      BEQ:     begin path[2] = 8; len = 3; end
      ADDI:    begin path[2] = 9; path[3] = 10; len = 4; end
      JMP:     begin path[2] = 11; len = 3; end
      default: len = 2;
    endcase
    op = op_v; funct = funct_v;
    i = 0; cyc = 0; mw_pulses = 0;
    while (i < len && cyc < 100) begin
      s = path[i];
      case (mode)
        0:       t = 1'b1;
        1:       t = 1'($urandom_range(0, 1));
        default: t = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      tick = t;
      halt = (s == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      zero = (s == 8) ? zero_v : 1'($urandom_range(0, 1));
      e_ir = t && (s == 0);
      e_mw = t && (s == 5);
      e_rw = t && (s == 4 || s == 7 || s == 10);
      e_pc = t && (s == 0 || s == 11 || (s == 8 && zero_v));
      @(negedge clk);
      total++;
      if (state !== 4'(s)) begin
        bad++; $display("FAIL state op=%b step=%0d: got %0d want %0d", op_v, i, state, s);
      end
      total++;
      if ({IRWrite, MemWrite, RegWrite, PCEn} !== {e_ir, e_mw, e_rw, e_pc}) begin
        bad++; $display("FAIL strobes op=%b state=%0d: got %b want %b", op_v, s,
                        {IRWrite, MemWrite, RegWrite, PCEn}, {e_ir, e_mw, e_rw, e_pc});
      end
      total++;
      if ({instr_cnt, illegal} !== {8'(m_cnt), m_illegal}) begin
        bad++; $display("FAIL cnt_illegal: got %0d/%b want %0d/%b", instr_cnt, illegal, m_cnt, m_illegal);
      end
      if (s == 6 || s == 8 || s == 0) begin
        total++;
        if (ULAControl !== ((s == 6) ? exp_alu(funct_v) : (s == 8) ? 3'b110 : 3'b010)) begin
          bad++; $display("FAIL ula state=%0d funct=%b: got %b", s, funct_v, ULAControl);
        end
      end
      if (s == 4 || s == 7) begin
        total++;
        if ({RegDst, MemtoReg} !== ((s == 4) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL wb_sel state=%0d: got %b", s, {RegDst, MemtoReg});
        end
      end
      if (s == 8 || s == 11) begin
        total++;
        if (PCSrc !== ((s == 8) ? 2'b01 : 2'b10)) begin
          bad++; $display("FAIL pcsrc state=%0d: got %b", s, PCSrc);
        end
      end
      if (s == 3 || s == 5) begin
        total++;
        if (IorD !== 1'b1) begin
          bad++; $display("FAIL iord state=%0d: got %b want 1", s, IorD);
        end
      end
      if (MemWrite) mw_pulses++;
      @(posedge clk); #1;
      if (t) begin
        if (len == 2 && i == 1) m_illegal = 1'b1;
        if (i == len - 1) m_cnt = (m_cnt + 1) % 256;
        i++;
      end
      cyc++;
    end
    total++;
    if (cyc >= 100) begin
      bad++; $display("FAIL timeout op=%b: stuck at step %0d", op_v, i);
    end
    total++;
    if (mw_pulses !== ((op_v == SW) ? 1 : 0)) begin
      bad++; $display("FAIL memwrite_pulses op=%b: got %0d want %0d", op_v, mw_pulses, (op_v == SW) ? 1 : 0);
    end
    tick = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; m_cnt = 0; m_illegal = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b1; halt = 1'b0; op = LW; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({state, instr_cnt, illegal, IRWrite, MemWrite, RegWrite, PCEn} !== 17'd0) begin
      bad++; $display("FAIL reset_state: state=%0d cnt=%0d ill=%b strobes=%b", state, instr_cnt,
                      illegal, {IRWrite, MemWrite, RegWrite, PCEn});
    end
    @(posedge clk); #1;
    rst = 1'b1; m_cnt = 0; m_illegal = 1'b0;
    run_instr(LW, 6'd0, 1'b0, 0);
    // Abort an LW while it is in MEMRD
    tick = 1'b1; halt = 1'b0; op = LW;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (state !== 4'd3) begin
      bad++; $display("FAIL reach_memrd: got %0d want 3", state);
    end
    rst = 1'b0; #1;
    total++;
    if ({state, instr_cnt, IRWrite, MemWrite, RegWrite, PCEn} !== 16'd0) begin
      bad++; $display("FAIL reset_mid_memrd: state=%0d cnt=%0d strobes=%b", state, instr_cnt,
                      {IRWrite, MemWrite, RegWrite, PCEn});
    end
    @(posedge clk); #1;
    rst = 1'b1; m_cnt = 0; tick = 1'b0;
  endtask

  task automatic test_lw();
    run_instr(LW, 6'($urandom), 1'b0, 0);
    run_instr(ADDI, 6'($urandom), 1'b0, 0);
  endtask

  task automatic test_r();
    run_instr(RT, 6'b100000, 1'b0, 0);
    run_instr(RT, 6'b100010, 1'b0, 0);
    run_instr(RT, 6'b101010, 1'b0, 0);
    run_instr(RT, 6'b100100, 1'b0, 1);
    run_instr(RT, 6'b100101, 1'b0, 1);
    run_instr(RT, 6'b111000, 1'b0, 1);
  endtask

  task automatic test_beq();
    run_instr(BEQ, 6'd0, 1'b1, 0);
    run_instr(BEQ, 6'd0, 1'b0, 0);
    run_instr(JMP, 6'd0, 1'b0, 0);
  endtask

  task automatic test_sw_tick();
    run_instr(SW, 6'd0, 1'b0, 2);
    run_instr(SW, 6'd0, 1'b0, 1);
  endtask

  task automatic test_halt();
    int c0;
    c0 = m_cnt;
    tick = 1'b1; halt = 1'b1; op = RT;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({state, IRWrite, PCEn, instr_cnt} !== {4'd0, 2'b00, 8'(c0)}) begin
        bad++; $display("FAIL halt_hold: state=%0d ir=%b pcen=%b cnt=%0d want cnt %0d",
                        state, IRWrite, PCEn, instr_cnt, c0);
      end
      @(posedge clk); #1;
    end
    halt = 1'b0; tick = 1'b0;
    run_instr(ADDI, 6'd0, 1'b0, 1);
  endtask

  task automatic test_illegal();
    run_instr(BAD, 6'd0, 1'b0, 0);
    run_instr(6'b010001, 6'd0, 1'b0, 1);
    run_instr(LW, 6'd0, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = ADDI; ops[5] = JMP; ops[6] = BAD;
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 6)], 6'($urandom), 1'($urandom_range(0, 1)), 1);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int n = 0; n < 255; n++) run_instr(JMP, 6'd0, 1'b0, 0);
    total++;
    if (instr_cnt !== 8'd255) begin
      bad++; $display("FAIL cnt_255: got %0d want 255", instr_cnt);
    end
    run_instr(JMP, 6'd0, 1'b0, 0);
    total++;
    if (instr_cnt !== 8'd0) begin
      bad++; $display("FAIL cnt_wrap: got %0d want 0", instr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_r();
    test_beq();
    test_sw_tick();
    test_halt();
    test_illegal();
    test_random();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
